// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single synchronous memory port: round-robin on
// collisions with a bounded burst lock for requester 1, one access per 4 cycles.
module mem_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r1_req,
  input  logic          r0_we,
  input  logic          r1_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic [DW-1:0] r1_wdata,
  input  logic          r1_lock,
  output logic          r0_gnt,
  output logic          r1_gnt,
  output logic          r0_ack,
  output logic          r1_ack,
  output logic [DW-1:0] r0_rdata,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;
  localparam logic [3:0] LOCK_LIM = 4'(MAX_LOCK);

  logic [1:0] state;
  logic       win;
  logic       last_grant;
  logic [3:0] lock_cnt;
  logic       pick1;

  // On a collision requester 1 wins if it was not served last, or if it holds
  // the lock and still has burst budget left.
  always_comb begin
    pick1 = r1_req;
    if (r0_req && r1_req)
      pick1 = !last_grant || (r1_lock && (lock_cnt < LOCK_LIM));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      win        <= 1'b0;
      last_grant <= 1'b1;
      lock_cnt   <= 4'd0;
      busy       <= 1'b0;
      r0_gnt     <= 1'b0;
      r1_gnt     <= 1'b0;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!r1_lock)
            lock_cnt <= 4'd0;
          if (r0_req || r1_req) begin
            state      <= S_ACCESS;
            busy       <= 1'b1;
            mem_en     <= 1'b1;
            win        <= pick1;
            last_grant <= pick1;
            r0_gnt     <= !pick1;
            r1_gnt     <= pick1;
            mem_we     <= pick1 ? r1_we    : r0_we;
            mem_addr   <= pick1 ? r1_addr  : r0_addr;
            mem_wdata  <= pick1 ? r1_wdata : r0_wdata;
            if (!pick1)
              lock_cnt <= 4'd0;
            else if (r1_lock && (lock_cnt != 4'hF))
              lock_cnt <= lock_cnt + 4'd1;
          end
        end
        S_ACCESS: begin
          state  <= S_WAIT;
          mem_en <= 1'b0;
          r0_gnt <= 1'b0;
          r1_gnt <= 1'b0;
        end
        S_WAIT: begin
          // Memory data for the access is valid in this cycle.
          if (!mem_we) begin
            if (win)
              r1_rdata <= mem_rdata;
            else
              r0_rdata <= mem_rdata;
          end
          r0_ack <= !win;
          r1_ack <= win;
          state  <= S_ACK;
        end
        default: begin
          r0_ack <= 1'b0;
          r1_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
